// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial pattern detector for an N-bit pattern that can be reloaded at run
//   time. Bits on w_i are sampled on rising edges of Clock while en_i is high;
//   the pattern MSB is the first bit of the sequence. Matches may overlap or
//   restart the history, z_o may be registered (Moore) or combinational
//   (Mealy), and a saturating counter with a sticky overflow flag tallies
//   matches.
//
// Ports
//   Clock        in   1      rising-edge clock
//   Resetn       in   1      asynchronous active-low reset
//   en_i         in   1      sample w_i at this edge
//   w_i          in   1      serial data bit
//   pat_load_i   in   1      load pat_in_i as the pattern (wins over en_i)
//   pat_in_i     in   N      new pattern, pat_in_i[N-1] is compared first
//   clr_cnt_i    in   1      synchronous clear of match_cnt_o / cnt_sat_o
//   z_o          out  1      match indication
//   match_cnt_o  out  CNT_W  saturating match count
//   cnt_sat_o    out  1      sticky: a match arrived while the count was full
//
// Detector phases (tracked by fill_q rather than an enumerated state)
//   state          | meaning
//   fill_q <  N-1  | history still filling, no match possible on this sample
//   fill_q >= N-1  | armed, this sample completes an N-bit window
//   fill_q == N    | history full (saturated)
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int             N           = 4,
  parameter logic [N-1:0]   DEFAULT_PAT = 4'b1011,
  parameter bit             OVERLAP     = 1'b1,
  parameter bit             MEALY       = 1'b0,
  parameter int             CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en_i,
  input  logic             w_i,
  input  logic             pat_load_i,
  input  logic [N-1:0]     pat_in_i,
  input  logic             clr_cnt_i,
  output logic             z_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cnt_sat_o
);

  localparam int FW = $clog2(N + 1);

  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [N-1:0]     window;
  logic             match;

  // Window as it will look once this cycle's bit is shifted in.
  assign window = {hist_q[N-2:0], w_i};
  assign match  = en_i & ~pat_load_i & (fill_q >= FW'(N - 1)) & (window == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    if (pat_load_i) begin
      pat_d  = pat_in_i;
      hist_d = '0;
      fill_d = '0;
    end else if (en_i) begin
      hist_d = window;
      if (match && !OVERLAP) begin
        // Non-overlapping: the matched bits may not seed the next match.
        fill_d = '0;
      end else if (fill_q != FW'(N)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEFAULT_PAT;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  generate
    if (MEALY) begin : g_mealy
      assign z_o = match;
    end else begin : g_moore
      logic z_q;
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) z_q <= 1'b0;
        else         z_q <= match;
      end
      assign z_o = z_q;
    end
  endgenerate

  assign match_cnt_o = cnt_q;
  assign cnt_sat_o   = sat_q;

endmodule
